// File: rtl/lcd_show_string.sv
// String sequencer for lcd_show_char: buffers up to BUF_DEPTH ASCII codes and issues one
// draw request per character, advancing the cursor, wrapping lines and truncating at the bottom.
module lcd_show_string #(
    parameter int  LCD_W     = 240,
    parameter int  LCD_H     = 320,
    parameter int  BUF_DEPTH = 32,
    localparam int AW        = $clog2(BUF_DEPTH)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          buf_wr_en,
    input  logic [AW-1:0] buf_wr_addr,
    input  logic [6:0]    buf_wr_data,
    input  logic          show_str_flag,
    input  logic [AW:0]   str_len,
    input  logic [8:0]    str_x,
    input  logic [8:0]    str_y,
    input  logic          en_size,
    input  logic          show_char_done,
    output logic          show_char_flag,
    output logic [6:0]    ascii_num,
    output logic [8:0]    char_x,
    output logic [8:0]    char_y,
    output logic          char_size,
    output logic          busy,
    output logic          show_str_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_e;

    localparam logic [9:0] LCD_W_C = 10'(LCD_W);
    localparam logic [9:0] LCD_H_C = 10'(LCD_H);
    localparam logic [AW:0] IDX_ONE = (AW + 1)'(1);

    state_e        state_q;
    logic [AW:0]   idx_q;
    logic [AW:0]   len_q;
    logic [8:0]    str_x_q;
    logic [9:0]    cur_x_q;
    logic [9:0]    cur_y_q;
    logic          size_q;
    logic          nl_q;
    logic          trunc_q;
    logic          flag_q;
    logic [6:0]    ascii_q;
    logic [8:0]    char_x_q;
    logic [8:0]    char_y_q;
    logic          busy_q;
    logic          done_q;

    logic [6:0]    buf_mem [BUF_DEPTH];

    // NOTE: the character buffer has no reset; its contents are don't-care until written,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge sys_clk) begin
        if (buf_wr_en && !busy_q) begin
            buf_mem[buf_wr_addr] <= buf_wr_data;
        end
    end

    logic [6:0]    code_d;
    logic          is_nl_d;
    logic [6:0]    font_idx_d;
    logic [9:0]    glyph_w_d;
    logic [9:0]    glyph_h_d;
    logic          wrap_d;
    logic [9:0]    draw_x_d;
    logic [9:0]    draw_y_d;
    logic          trunc_d;
    logic [AW:0]   idx_d;

    // Decode of the current buffer entry and placement of the glyph, consumed in LOAD.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        code_d     = buf_mem[idx_q[AW-1:0]];
        is_nl_d    = 1'b0;
        font_idx_d = 7'd0;
        glyph_w_d  = size_q ? 10'd8  : 10'd6;
        glyph_h_d  = size_q ? 10'd16 : 10'd12;
        if (code_d == 7'h0A) begin
            is_nl_d = 1'b1;
        end else if (code_d >= 7'h20 && code_d != 7'h7F) begin
            font_idx_d = code_d - 7'h20;
        end
        wrap_d   = (cur_x_q + glyph_w_d) > LCD_W_C;
        draw_x_d = wrap_d ? {1'b0, str_x_q} : cur_x_q;
        draw_y_d = wrap_d ? (cur_y_q + glyph_h_d) : cur_y_q;
        trunc_d  = (draw_y_d + glyph_h_d) > LCD_H_C;
        idx_d    = idx_q + IDX_ONE;
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            str_x_q  <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            size_q   <= 1'b0;
            nl_q     <= 1'b0;
            trunc_q  <= 1'b0;
            flag_q   <= 1'b0;
            ascii_q  <= '0;
            char_x_q <= '0;
            char_y_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    // busy_q is still high for the one IDLE cycle after DONE, which also
                    // blocks a back-to-back start and buffer writes in that cycle.
                    if (show_str_flag && !busy_q) begin
                        busy_q  <= 1'b1;
                        len_q   <= str_len;
                        str_x_q <= str_x;
                        cur_x_q <= {1'b0, str_x};
                        cur_y_q <= {1'b0, str_y};
                        size_q  <= en_size;
                        idx_q   <= '0;
                        state_q <= (str_len == '0) ? S_DONE : S_LOAD;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    nl_q    <= is_nl_d;
                    trunc_q <= 1'b0;
                    if (!is_nl_d) begin
                        cur_x_q <= draw_x_d;
                        cur_y_q <= draw_y_d;
                        trunc_q <= trunc_d;
                        if (!trunc_d) begin
                            flag_q   <= 1'b1;
                            ascii_q  <= font_idx_d;
                            char_x_q <= draw_x_d[8:0];
                            char_y_q <= draw_y_d[8:0];
                        end
                    end
                    state_q <= S_FIRE;
                end
                S_FIRE: begin
                    flag_q <= 1'b0;
                    if (nl_q) begin
                        state_q <= S_NEXT;
                    end else if (trunc_q) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (show_char_done) begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (nl_q) begin
                        cur_x_q <= {1'b0, str_x_q};
                        cur_y_q <= cur_y_q + glyph_h_d;
                    end else begin
                        cur_x_q <= cur_x_q + glyph_w_d;
                    end
                    idx_q   <= idx_d;
                    state_q <= (idx_d == len_q) ? S_DONE : S_LOAD;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign show_char_flag = flag_q;
    assign ascii_num      = ascii_q;
    assign char_x         = char_x_q;
    assign char_y         = char_y_q;
    assign char_size      = size_q;
    assign busy           = busy_q;
    assign show_str_done  = done_q;

endmodule
